// File: rtl/i2cmb_wb_sequencer.sv
// Turns one I2C transfer request into the full I2CMB Wishbone register sequence.
// Optional macro I2CMB_SEQ_IRQ_EN: wait for irq_i instead of polling CMDR.
module i2cmb_wb_sequencer #(
  parameter int NUM_BUSSES = 16,
  parameter int MAX_LEN    = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [3:0] req_bus,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       done,
  output logic [1:0] status,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       irq_i
);

  localparam logic [1:0] ADR_CSR = 2'd0, ADR_DPR = 2'd1, ADR_CMDR = 2'd2;
  localparam logic [1:0] ST_OK = 2'd0, ST_NAK = 2'd1, ST_AL = 2'd2, ST_ERR = 2'd3;
`ifdef I2CMB_SEQ_IRQ_EN
  localparam logic [7:0] CSR_INIT = 8'hC0;
`else
  localparam logic [7:0] CSR_INIT = 8'h80;
`endif

  typedef enum logic [3:0] {
    INIT, IDLE, SETBUS, START, ADDR, WDATA, RDATA, STOP, WAIT, REPORT
  } state_t;

  state_t     state, state_n, ret_state, ret_n;
  logic [1:0] ph, ph_n, ret_ph, ret_ph_n;
  logic [1:0] fin, fin_n;
  logic       rw_q;
  logic [3:0] bus_q;
  logic [6:0] addr_q;
  logic [7:0] len_q, cnt, wbyte;
  logic       ack, accept, last, cnt_inc, rd_load, poll_en;
  logic       iss, iss_we;
  logic [1:0] iss_adr;
  logic [7:0] iss_dat;

  assign ack    = wb_cyc_o & wb_ack_i;
  assign accept = req_valid & req_ready & (state == IDLE);
  assign last   = (cnt == len_q - 8'd1);

`ifdef I2CMB_SEQ_IRQ_EN
  assign poll_en = irq_i;
`else
  logic unused_irq;
  assign unused_irq = irq_i;
  assign poll_en    = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    ph_n     = ph;
    ret_n    = ret_state;
    ret_ph_n = ret_ph;
    fin_n    = fin;
    iss      = 1'b0;
    iss_we   = 1'b1;
    iss_adr  = ADR_CMDR;
    iss_dat  = 8'h00;
    cnt_inc  = 1'b0;
    rd_load  = 1'b0;
    case (state)
      INIT: begin
        iss     = 1'b1;
        iss_adr = ADR_CSR;
        iss_dat = CSR_INIT;
        if (ack) state_n = IDLE;
      end
      IDLE: begin
        if (accept) begin
          ph_n  = 2'd0;
          fin_n = ST_OK;
          // Bad requests finish without touching the bus.
          if (({1'b0, req_bus} >= 5'(NUM_BUSSES)) || ({1'b0, req_len} > 9'(MAX_LEN))) begin
            fin_n   = ST_ERR;
            state_n = REPORT;
          end else begin
            state_n = SETBUS;
          end
        end
      end
      SETBUS: begin
        iss     = 1'b1;
        iss_adr = (ph == 2'd0) ? ADR_DPR : ADR_CMDR;
        iss_dat = (ph == 2'd0) ? {4'h0, bus_q} : 8'h06;
        if (ack) begin
          if (ph == 2'd0) ph_n = 2'd1;
          else begin state_n = WAIT; ret_n = START; ret_ph_n = 2'd0; end
        end
      end
      START: begin
        iss     = 1'b1;
        iss_dat = 8'h04;
        if (ack) begin state_n = WAIT; ret_n = ADDR; ret_ph_n = 2'd0; end
      end
      ADDR: begin
        iss     = 1'b1;
        iss_adr = (ph == 2'd0) ? ADR_DPR : ADR_CMDR;
        iss_dat = (ph == 2'd0) ? {addr_q, rw_q} : 8'h01;
        if (ack) begin
          if (ph == 2'd0) ph_n = 2'd1;
          else begin
            state_n  = WAIT;
            ret_ph_n = 2'd0;
            ret_n    = (len_q == 8'd0) ? STOP : (rw_q ? RDATA : WDATA);
          end
        end
      end
      WDATA: begin
        // ph0 wait for a byte, ph1 ready pulse, ph2 DPR write, ph3 command
        case (ph)
          2'd0: if (wr_valid) ph_n = 2'd1;
          2'd1: ph_n = 2'd2;
          2'd2: begin
            iss     = 1'b1;
            iss_adr = ADR_DPR;
            iss_dat = wbyte;
            if (ack) ph_n = 2'd3;
          end
          default: begin
            iss     = 1'b1;
            iss_dat = 8'h01;
            if (ack) begin
              cnt_inc  = 1'b1;
              state_n  = WAIT;
              ret_n    = last ? STOP : WDATA;
              ret_ph_n = 2'd0;
            end
          end
        endcase
      end
      RDATA: begin
        case (ph)
          2'd0: begin
            iss     = 1'b1;
            iss_dat = last ? 8'h03 : 8'h02;
            if (ack) begin state_n = WAIT; ret_n = RDATA; ret_ph_n = 2'd1; end
          end
          2'd1: begin
            iss     = 1'b1;
            iss_we  = 1'b0;
            iss_adr = ADR_DPR;
            if (ack) begin rd_load = 1'b1; ph_n = 2'd2; end
          end
          default: begin
            if (rd_valid && rd_ready) begin
              cnt_inc = 1'b1;
              ph_n    = 2'd0;
              if (last) state_n = STOP;
            end
          end
        endcase
      end
      STOP: begin
        iss     = 1'b1;
        iss_dat = 8'h05;
        if (ack) begin state_n = WAIT; ret_n = REPORT; ret_ph_n = 2'd0; end
      end
      WAIT: begin
        iss    = poll_en;
        iss_we = 1'b0;
        if (ack) begin
          if (wb_dat_i[5]) begin
            fin_n   = ST_AL;
            state_n = REPORT;
          end else if (wb_dat_i[4]) begin
            fin_n   = ST_ERR;
            state_n = REPORT;
          end else if (wb_dat_i[6]) begin
            fin_n   = ST_NAK;
            state_n = (ret_state == REPORT) ? REPORT : STOP;
            ph_n    = 2'd0;
          end else if (wb_dat_i[7]) begin
            state_n = ret_state;
            ph_n    = ret_ph;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= INIT;
      ph        <= 2'd0;
      ret_state <= IDLE;
      ret_ph    <= 2'd0;
      fin       <= ST_OK;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
      done      <= 1'b0;
      status    <= ST_OK;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      ret_state <= ret_n;
      ret_ph    <= ret_ph_n;
      fin       <= fin_n;
      req_ready <= (state_n == IDLE);
      wr_ready  <= (state == WDATA) && (ph == 2'd0) && wr_valid;
      done      <= (state == REPORT);
      if (state == REPORT) status <= fin;
      if (rd_load) begin
        rd_valid <= 1'b1;
        rd_data  <= wb_dat_i;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Wishbone master: load on issue, hold until ack, drop for one idle cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 2'd0;
      wb_dat_o <= 8'h00;
    end else if (wb_cyc_o) begin
      if (wb_ack_i) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_adr_o <= 2'd0;
        wb_dat_o <= 8'h00;
      end
    end else if (iss) begin
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_we_o  <= iss_we;
      wb_adr_o <= iss_adr;
      wb_dat_o <= iss_dat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      rw_q   <= req_rw;
      bus_q  <= req_bus;
      addr_q <= req_addr;
      len_q  <= req_len;
      cnt    <= 8'd0;
    end else if (cnt_inc) begin
      cnt <= cnt + 8'd1;
    end
    if (wr_ready && wr_valid) wbyte <= wr_data;
  end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Directed bench for i2cmb_wb_sequencer with a behavioural I2CMB Wishbone slave.
module tb_i2cmb_wb_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rw;
  logic [3:0] req_bus;
  logic [6:0] req_addr;
  logic [7:0] req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       done;
  logic [1:0] status;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [1:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_ack_i;
  logic       irq_i;

  i2cmb_wb_sequencer #(.NUM_BUSSES(8), .MAX_LEN(255)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bus(req_bus), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .status(status),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .irq_i(irq_i)
  );

  always #5 clk = ~clk;

`ifdef I2CMB_SEQ_IRQ_EN
  localparam logic [9:0] CSR_EXP = 10'h0C0;
`else
  localparam logic [9:0] CSR_EXP = 10'h080;
`endif

  // Slave model: zero-wait ack, scripted CMDR status, DPR read bytes.
  logic [9:0] wlog[$];
  int         acc_cnt = 0, cmd_cnt = 0, cmdr_rd = 0, dpr_rd = 0, viol = 0;
  int         busy_left = 0, busy_cfg = 0, fault_at = -1, rbase = 0;
  logic [7:0] fault_val = 8'h00, cur_stat = 8'h80;
  logic [7:0] rbytes [8];
  logic       last_ack = 1'b0;

  assign wb_ack_i = wb_cyc_o & wb_stb_o;
  assign irq_i    = 1'b1;

  always_comb begin
    wb_dat_i = 8'h00;
    if (wb_adr_o == 2'd2) wb_dat_i = (busy_left != 0) ? 8'h00 : cur_stat;
    else if (wb_adr_o == 2'd1) wb_dat_i = rbytes[3'(dpr_rd - rbase)];
  end

  always @(posedge clk) begin
    last_ack <= wb_cyc_o & wb_stb_o & wb_ack_i;
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      acc_cnt <= acc_cnt + 1;
      if (wb_we_o) begin
        wlog.push_back({wb_adr_o, wb_dat_o});
        if (wb_adr_o == 2'd2) begin
          cur_stat  <= (cmd_cnt == fault_at) ? fault_val : 8'h80;
          busy_left <= busy_cfg;
          cmd_cnt   <= cmd_cnt + 1;
        end
      end else if (wb_adr_o == 2'd2) begin
        cmdr_rd <= cmdr_rd + 1;
        if (busy_left > 0) busy_left <= busy_left - 1;
      end else if (wb_adr_o == 2'd1) begin
        dpr_rd <= dpr_rd + 1;
      end
    end
  end

  // Bus must be idle the cycle after an ack, and stb tracks cyc.
  always @(negedge clk)
    if ((last_ack && wb_cyc_o) || (wb_cyc_o != wb_stb_o)) viol <= viol + 1;

  int         n_cmp = 0, n_err = 0;
  logic [9:0] ew[$];
  logic [7:0] wdat [8];
  int         wn;
  logic [7:0] rd_got [8];
  int         rgot_n, wr_pulses;
  logic       seen;
  logic [1:0] st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_wlog(input string tag, input int base);
    chk({tag, "_nwr"}, wlog.size() - base, ew.size());
    for (int i = 0; i < ew.size() && base + i < wlog.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(wlog[base + i]), 32'(ew[i]));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    chk(tag, 32'(req_ready), 32'd1);
  endtask

  task automatic xfer(input logic rw, input logic [3:0] bus, input logic [6:0] addr,
                      input logic [7:0] len);
    int   widx;
    logic hs;
    widx = 0; hs = 1'b0; seen = 1'b0; st = 2'd0; rgot_n = 0; wr_pulses = 0;
    req_rw = rw; req_bus = bus; req_addr = addr; req_len = len;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 800 && !seen; i++) begin
      @(negedge clk);
      if (hs) begin widx++; hs = 1'b0; end
      wr_valid = (widx < wn);
      wr_data  = wdat[widx[2:0]];
      if (wr_ready) wr_pulses++;
      if (wr_valid && wr_ready) hs = 1'b1;
      if (rd_valid && rd_ready && rgot_n < 8) begin
        rd_got[rgot_n[2:0]] = rd_data;
        rgot_n++;
      end
      if (done) begin seen = 1'b1; st = status; end
    end
    wr_valid = 1'b0;
  endtask

  int b, a0, c0, stops;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_bus = 4'd0; req_addr = 7'd0;
    req_len = 8'd0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b1; wn = 0;
    for (int i = 0; i < 8; i++) begin rbytes[i] = 8'h00; wdat[i] = 8'h00; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wb_ctl", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    chk("rst_wb_adr_dat", 32'({wb_adr_o, wb_dat_o}), 32'd0);
    chk("rst_outs", 32'({wr_ready, rd_valid, done, status, rd_data}), 32'd0);
    rst = 1'b0;
    wait_idle("init_idle");
    ew = '{CSR_EXP};
    chk_wlog("init", 0);

    // Write of two bytes with one busy poll per command
    busy_cfg = 1; c0 = cmdr_rd; b = wlog.size();
    wdat[0] = 8'hA5; wdat[1] = 8'h5A; wn = 2;
    xfer(1'b0, 4'd2, 7'h22, 8'd2);
    chk("wr_done", 32'(seen), 32'd1);
    chk("wr_status", 32'(st), 32'd0);
    chk("wr_pulses", wr_pulses, 2);
    chk("wr_polls", cmdr_rd - c0, 12);
    ew = '{10'h102, 10'h206, 10'h204, 10'h144, 10'h201, 10'h1A5, 10'h201, 10'h15A,
           10'h201, 10'h205};
    chk_wlog("wr", b);
    busy_cfg = 0; wn = 0;

    // Read of three bytes
    rbase = dpr_rd; rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33;
    b = wlog.size();
    xfer(1'b1, 4'd0, 7'h22, 8'd3);
    chk("rd_status", 32'({seen, st}), 32'h4);
    chk("rd_count", rgot_n, 3);
    chk("rd_byte0", 32'(rd_got[0]), 32'h11);
    chk("rd_byte1", 32'(rd_got[1]), 32'h22);
    chk("rd_byte2", 32'(rd_got[2]), 32'h33);
    ew = '{10'h100, 10'h206, 10'h204, 10'h145, 10'h201, 10'h202, 10'h202, 10'h203, 10'h205};
    chk_wlog("rd", b);

    // Address-only probe
    b = wlog.size();
    xfer(1'b0, 4'd3, 7'h10, 8'd0);
    chk("probe_status", 32'({seen, st}), 32'h4);
    ew = '{10'h103, 10'h206, 10'h204, 10'h120, 10'h201, 10'h205};
    chk_wlog("probe", b);

    // Address NAK: Stop follows, no write bytes pulled
    b = wlog.size(); fault_at = cmd_cnt + 2; fault_val = 8'h40;
    wdat[0] = 8'h77; wdat[1] = 8'h88; wn = 2;
    xfer(1'b0, 4'd1, 7'h50, 8'd2);
    chk("nak_status", 32'({seen, st}), 32'h5);
    chk("nak_wr_pulses", wr_pulses, 0);
    ew = '{10'h101, 10'h206, 10'h204, 10'h1A0, 10'h201, 10'h205};
    chk_wlog("nak", b);
    wn = 0;

    // Arbitration lost on Start: no Stop
    b = wlog.size(); fault_at = cmd_cnt + 1; fault_val = 8'h20;
    xfer(1'b0, 4'd5, 7'h22, 8'd1);
    chk("al_status", 32'({seen, st}), 32'h6);
    ew = '{10'h105, 10'h206, 10'h204};
    chk_wlog("al", b);
    fault_at = -1;

    // Bus id out of range: immediate ERR, no Wishbone traffic
    a0 = acc_cnt;
    xfer(1'b0, 4'd15, 7'h22, 8'd1);
    chk("badbus_status", 32'({seen, st}), 32'h7);
    chk("badbus_no_wb", acc_cnt - a0, 0);

    // Reset while a read byte is waiting for rd_ready
    rd_ready = 1'b0; rbase = dpr_rd; rbytes[0] = 8'h9C; b = wlog.size();
    req_rw = 1'b1; req_bus = 4'd0; req_addr = 7'h22; req_len = 8'd2; req_valid = 1'b1;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 200 && !rd_valid; i++) @(negedge clk);
    chk("rr_rd_valid_pre", 32'({rd_valid, rd_data}), 32'h19C);
    rst = 1'b1;
    a0 = wlog.size();
    @(negedge clk);
    chk("rr_rd_valid_drop", 32'(rd_valid), 32'd0);
    chk("rr_wb_idle", 32'(wb_cyc_o), 32'd0);
    rst = 1'b0;
    rd_ready = 1'b1;
    wait_idle("rr_idle");
    stops = 0;
    for (int i = b; i < wlog.size(); i++) if (wlog[i] == 10'h205) stops++;
    chk("rr_no_stop", stops, 0);
    chk("rr_init_n", wlog.size() - a0, 1);
    if (wlog.size() > a0) chk("rr_init_csr", 32'(wlog[a0]), 32'(CSR_EXP));

    chk("wb_idle_gap", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2cmb_wb_sequencer.md
# i2cmb_wb_sequencer

Hardware command sequencer that sits between a simple request/stream interface and the Wishbone slave port of the I2CMB core. It turns one request (bus, 7-bit address, direction, byte count) into the complete I2CMB register sequence: enable, Set Bus, Start, address, data bytes and Stop. It waits for each I2CMB command to finish and reports a per-transfer status. It owns the I2CMB Wishbone port exclusively; no other master is present.

## Interface
- NUM_BUSSES, 16: number of I2C busses; a req_bus value ≥ NUM_BUSSES completes immediately with status ERR.
- MAX_LEN, 255: largest accepted req_len.

- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_rw  in  1  0 = write, 1 = read
- req_bus  in  4  I2C bus id
- req_addr  in  7  I2C slave address
- req_len  in  8  data byte count (0 = address-only probe)
- wr_valid / wr_ready  in/out  1  write-byte handshake
- wr_data  in  8  write byte
- rd_valid / rd_ready  out/in  1  read-byte handshake
- rd_data  out  8  read byte
- done  out  1  one-cycle completion pulse
- status  out  2  0 OK, 1 NAK, 2 ARB_LOST, 3 ERR; valid while done=1 and held until the next done
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master controls
- wb_adr_o  out  2  0 CSR, 1 DPR, 2 CMDR, 3 FSMR
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  I2CMB interrupt

## Operation
- FSM states: INIT, IDLE, SETBUS, START, ADDR, WDATA, RDATA, STOP, WAIT, REPORT.
- INIT (first state after reset) writes CSR = 0xC0 (E and IE), or 0x80 without the IRQ feature, then enters IDLE.
- IDLE: req_ready = 1. On accept, latch all request fields and clear the byte counter.
- SETBUS: DPR ← req_bus, then CMDR ← 0x06.
- START: CMDR ← 0x04.
- ADDR: DPR ← {addr, rw}, then CMDR ← 0x01.
- WDATA: repeat req_len times. Assert wr_ready for exactly one cycle on wr_valid, then DPR ← wr_data and CMDR ← 0x01.
- RDATA: repeat req_len times. CMDR ← 0x02 (ACK); the last byte uses 0x03 (NAK). Then read DPR and present it on rd_data with rd_valid until rd_ready. The next byte is not commanded before the handshake completes.
- STOP: CMDR ← 0x05.
- Every CMDR command write is followed by WAIT, which obtains the CMDR status byte:
  - DON (bit 7): resume the sequence.
  - NAK (bit 6): go to STOP, final status NAK.
  - AL (bit 5): go to REPORT, no Stop, status ARB_LOST.
  - ERR (bit 4): go to REPORT, no Stop, status ERR.
- A NAK on a data write aborts the remaining bytes, and no further wr_ready pulses occur.
- REPORT: pulse done with status, return to IDLE.

## Timing
- Reset values: req_ready 0, wr_ready 0, rd_valid 0, rd_data 0, done 0, status 0, wb_cyc_o/stb_o/we_o 0, wb_adr_o 0, wb_dat_o 0.
- rst_i asserted mid-transfer aborts immediately, with no Stop issued; INIT reruns after release.
- Wishbone access:
  - cyc/stb/we/adr/dat are registered and held stable until the cycle wb_ack_i = 1.
  - All are deasserted the following cycle.
  - At least one idle cycle separates consecutive accesses.
  - No timeout: a missing ack stalls indefinitely.
- wr_ready and done are single-cycle pulses.
- req_ready is 0 in every state except IDLE.
- Minimum latency from request accept to done for a len-0 write with no wait states: 2+1+2+1 command phases plus 4 status reads, each access 2 cycles (stb, idle).
- req_len > MAX_LEN: status ERR, no Wishbone traffic.

## Configuration
- I2CMB_SEQ_IRQ_EN defined:
  - CSR init value 0xC0.
  - WAIT idles with cyc = 0 until irq_i = 1, then performs exactly one CMDR read, which clears the interrupt.
- Undefined:
  - CSR init value 0x80 and irq_i is ignored.
  - WAIT polls with CMDR reads separated by one idle cycle until any of bits 7:4 is set.

## Test plan
- Reset then idle: first Wishbone access is a CSR write of 0xC0 (IRQ build) or 0x80; req_ready rises afterwards.
- Write bus 2, addr 0x22, len 2, data 0xA5 0x5A: DPR/CMDR writes 02/06, –/04, 44/01, A5/01, 5A/01, –/05 in order; done with status 0.
- Read bus 0, addr 0x22, len 3, slave bytes 0x11 0x22 0x33: CMDR 02, 02, 03; rd_data 11, 22, 33; Stop issued; status 0.
- Address NAK (CMDR returns 0x40 after ADDR): the next command is Stop 0x05, no wr_ready pulses occur, status 1.
- Arbitration lost during Start (CMDR returns 0x20): no Stop issued, status 2; req_bus = 15 with NUM_BUSSES = 8 gives immediate status 3 and no Wishbone cycle.
- rst_i pulsed during RDATA with rd_valid = 1: rd_valid drops the next cycle, no Stop is issued, and CSR init is repeated.
